alu_cmd_sequencer: RTL and testbench

// - Upstream issue stage for the combinational 8-bit alu: buffers operand/opcode commands from a producer,

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_seq_fifo.sv | 62 ++++++
 rtl/alu_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: default widths,
// the illegal opcode value and the sequencer FSM state encoding.
package alu_seq_pkg;

    localparam int DW_DEF  = 8;
    localparam int OPW_DEF = 3;

    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO for the ALU sequencer.
// Pointers wrap modulo DEPTH (power of two); an extra count bit separates
// full from empty. Push is ignored when full, pop ignored when empty.
module alu_seq_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem[rd_ptr];

    // Storage array: data only, left unreset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: buffers commands in a FIFO, drives
// one command at a time onto the ALU inputs, captures the result and hands
// it to the consumer with valid/ready. Illegal opcode yields result 0, err 1.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds out_zero_o.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [DW-1:0]  in_a_i,
    input  logic [DW-1:0]  in_b_i,
    input  logic [OPW-1:0] in_op_i,
    output logic [DW-1:0]  alu_a_o,
    output logic [DW-1:0]  alu_b_o,
    output logic [OPW-1:0] alu_op_o,
    input  logic [DW-1:0]  alu_res_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [DW-1:0]  out_res_o,
    output logic           out_err_o
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic           out_zero_o
`endif
);

    localparam int CW = 2 * DW + OPW;

    seq_state_e     state;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_wdata;
    logic [CW-1:0]  fifo_rdata;
    logic [DW-1:0]  head_a;
    logic [DW-1:0]  head_b;
    logic [OPW-1:0] head_op;
    logic           op_illegal;
    logic [DW-1:0]  res_capture;

    // Illegal opcodes report a forced-zero result
    function automatic logic [DW-1:0] capture_result(input logic illegal,
                                                     input logic [DW-1:0] res);
        return illegal ? '0 : res;
    endfunction

    assign in_ready_o  = ~fifo_full;
    assign fifo_push   = in_valid_i & ~fifo_full;
    assign fifo_wdata  = {in_a_i, in_b_i, in_op_i};
    assign {head_a, head_b, head_op} = fifo_rdata;
    assign op_illegal  = (alu_op_o == OPW'(OP_ILLEGAL));
    assign res_capture = capture_result(op_illegal, alu_res_i);

    alu_seq_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pop the head whenever the FSM is about to issue a new command
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: fifo_pop = ~fifo_empty;
            ST_RESP: fifo_pop = out_ready_i & ~fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Sequencer FSM with registered ALU drive and result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_op_o    <= '0;
            out_valid_o <= 1'b0;
            out_res_o   <= '0;
            out_err_o   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            out_zero_o  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a_o  <= head_a;
                        alu_b_o  <= head_b;
                        alu_op_o <= head_op;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    out_res_o   <= res_capture;
                    out_err_o   <= op_illegal;
                    out_valid_o <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    out_zero_o  <= (res_capture == '0);
`endif
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (!fifo_empty) begin
                            alu_a_o  <= head_a;
                            alu_b_o  <= head_b;
                            alu_op_o <= head_op;
                            state    <= ST_ISSUE;
                        end else begin
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU on alu_*_o, directed
// scenarios plus randomized bursts checked against a queue-based model.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic       out_err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_res_q[$];
    logic       exp_err_q[$];

    int         n;
    int         burst_n;
    logic [7:0] held_res;
    logic       held_err;
    logic       holding;
    logic [7:0] burst_exp [5];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [2:0] rop;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_a, alu_b, alu_op);

    alu_cmd_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_op_i     (in_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_res_i   (alu_res),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_res_o   (out_res),
        .out_err_o   (out_err)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .out_zero_o  (out_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one command starting at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int w;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("send_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            exp_err_q.push_back(op == 3'd7);
            exp_res_q.push_back((op == 3'd7) ? 8'd0 : alu_fn(a, b, op));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Accept one result and compare with the oldest expectation
    task automatic recv(input string tag);
        int w;
        logic [7:0] er;
        logic       ee;
        out_ready = 1'b1;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid || exp_res_q.size() == 0) begin
            chk({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
        end else begin
            er = exp_res_q.pop_front();
            ee = exp_err_q.pop_front();
            chk({tag, "_res"}, {24'd0, out_res}, {24'd0, er});
            chk({tag, "_err"}, {31'd0, out_err}, {31'd0, ee});
`ifdef ALU_SEQ_ZERO_FLAG_EN
            chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (er == 8'd0)});
`endif
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_res", {24'd0, out_res}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single command latency: accept on E0, valid after E2
        in_valid = 1'b1; in_a = 8'd10; in_b = 8'd3; in_op = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_e0_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_res", {24'd0, out_res}, 32'd13);
        chk("lat_err", {31'd0, out_err}, 32'd0);
        chk("lat_alu_a", {24'd0, alu_a}, 32'd10);
        chk("lat_alu_b", {24'd0, alu_b}, 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("lat_drop_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_alu_a", {24'd0, alu_a}, 32'd10);
        chk("hold_alu_op", {29'd0, alu_op}, 32'd0);

        // Burst of 5 with consumer stalled: 1 in flight + 4 buffered, then full
        burst_exp[0] = 8'd13; burst_exp[1] = 8'd7; burst_exp[2] = 8'd2;
        burst_exp[3] = 8'd11; burst_exp[4] = 8'd11;
        for (int i = 0; i < 5; i++) begin
            chk("burst_ready", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1; in_a = 8'd10; in_b = 8'd3; in_op = 3'(i);
            @(negedge clk);
        end
        in_a = 8'd1; in_b = 8'd1; in_op = 3'd0;
        for (int i = 0; i < 10; i++) begin
            chk("full_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_res", {24'd0, out_res}, 32'd13);
            chk("stall_err", {31'd0, out_err}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("burst_valid", {31'd0, out_valid}, 32'd1);
            chk("burst_res", {24'd0, out_res}, {24'd0, burst_exp[i]});
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("burst_no_extra", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Illegal opcode then a legal one
        send(8'd10, 8'd3, 3'd7);
        recv("illegal");
        send(8'd10, 8'd3, 3'd1);
        recv("after_illegal");
        chk("after_illegal_lit", {24'd0, out_res}, 32'd7);

`ifdef ALU_SEQ_ZERO_FLAG_EN
        send(8'd3, 8'd3, 3'd1);
        recv("zero_set");
        chk("zero_set_lit", {31'd0, out_zero}, 32'd1);
        send(8'd10, 8'd3, 3'd0);
        recv("zero_clr");
        chk("zero_clr_lit", {31'd0, out_zero}, 32'd0);
`endif

        // Randomized bursts drained with a randomly stalling consumer
        for (int it = 0; it < 30; it++) begin
            burst_n = int'($urandom_range(1, 5));
            for (int k = 0; k < burst_n; k++) begin
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rop = 3'($urandom);
                send(ra, rb, rop);
            end
            holding = 1'b0;
            n = 0;
            while (exp_res_q.size() != 0 && n < 200) begin
                out_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (out_valid && holding) begin
                    chk("rand_stable_res", {24'd0, out_res}, {24'd0, held_res});
                    chk("rand_stable_err", {31'd0, out_err}, {31'd0, held_err});
                end
                if (out_valid && out_ready) begin
                    chk("rand_res", {24'd0, out_res}, {24'd0, exp_res_q.pop_front()});
                    chk("rand_err", {31'd0, out_err}, {31'd0, exp_err_q.pop_front()});
                    holding = 1'b0;
                end else if (out_valid) begin
                    held_res = out_res;
                    held_err = out_err;
                    holding  = 1'b1;
                end
                @(negedge clk);
                n++;
            end
            chk("rand_drained", exp_res_q.size(), 32'd0);
            out_ready = 1'b0;
        end

        // Asynchronous reset while a result is pending with two queued
        send(8'd10, 8'd3, 3'd0);
        send(8'd1, 8'd2, 3'd0);
        send(8'd5, 8'd5, 3'd2);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_res", {24'd0, out_res}, 32'd0);
        chk("arst_err", {31'd0, out_err}, 32'd0);
        chk("arst_alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("arst_zero", {31'd0, out_zero}, 32'd0);
`endif
        exp_res_q.delete();
        exp_err_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
